ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage RV32 pipeline: consumes the ID/EX bundle, performs ALU/compare, resolves branches and jumps, runs an iterative 32-cycle multiplier for MUL, and drives the EX/MEM register that feeds the memory stage. It honours the memory stage's stall, inserts bubbles while a multiply is in flight, and back-pressures decode through `ex_stall`.

## Interface
- BIT_W, 32, datapath width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pc_in  in  BIT_W  PC of instruction in EX
- rs1_in, rs2_in  in  BIT_W  forwarded register operands
- imm_in  in  BIT_W  sign-extended immediate
- alusrc_a_in  in  1  0: rs1, 1: pc
- alusrc_b_in  in  1  0: rs2, 1: imm
- alu_op_in  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, others ADD
- branch_in  in  1  conditional branch
- br_type_in  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- jal_in, jalr_in  in  1  unconditional jumps
- memrd_in, memwr_in, mem2reg_in, regwr_in  in  1  control passed to MEM
- rd_in  in  5  destination register
- mem_stall_in  in  1  MEM stage cannot accept (dcache stall on load/store)
- alu_result_out  out  BIT_W  EX/MEM result
- mem_wdata_out  out  BIT_W  store data (rs2_in)
- PC_plus_4_out  out  BIT_W
- rd_out  out  5
- memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out  out  1
- redirect  out  1  taken branch/jump this cycle
- redirect_pc  out  BIT_W  target
- ex_stall  out  1  decode/fetch must hold the ID/EX bundle

## Operation
- opA = alusrc_a ? pc : rs1; opB = alusrc_b ? imm : rs2. Shifts use opB[4:0]; SRA arithmetic; SLT signed, SLTU unsigned; results 1/0 zero-extended.
- Branch compare on rs1 vs rs2 per br_type. Target: branch/JAL = pc + imm; JALR = (rs1 + imm) & ~1, all mod 2^32.
- redirect = (jal | jalr | (branch & taken)) & ~mem_stall_in; combinational. jump_out = jal | jalr.
- PC_plus_4_out = pc + 4 (wraps).
- Multiplier FSM (low 32 bits of product, signedness irrelevant):
  - IDLE: alu_op==MUL and !mem_stall_in → load mcand=opA, mplier=opB, acc=0, cnt=0; go MUL.
  - MUL: each cycle acc += mplier[0] ? mcand : 0; mcand <<= 1; mplier >>= 1; cnt++. After the 32nd step go DONE.
  - DONE: result = acc; when !mem_stall_in, EX/MEM captures it, go IDLE; else stay DONE.
- ex_stall = mem_stall_in | (alu_op==MUL & state!=DONE).
- EX/MEM update per cycle:
  - mem_stall_in: hold all outputs.
  - else ex_stall (multiply pending): load bubble (regwr, memrd, memwr, mem2reg, jump = 0; data fields don't-care, drive 0).
  - else: load computed bundle.

## Timing
- Reset: all registered outputs 0, FSM IDLE, acc/cnt 0; redirect/ex_stall follow inputs combinationally. Reset mid-multiply aborts to IDLE.
- Non-MUL latency: 1 cycle (inputs at edge N → outputs valid after edge N+1).
- MUL: enters EX in cycle 0 (IDLE), ex_stall high cycles 0–32 (33 cycles), DONE in cycle 33 with ex_stall low; result on outputs after edge ending cycle 33. Each extra mem_stall_in cycle in DONE adds one.
- mem_stall_in during MUL iteration: FSM keeps iterating; only EX/MEM holds.
- mem_stall_in in IDLE with MUL pending: no launch until it drops.
- Upstream must keep ID/EX inputs stable while ex_stall is high.

## Test plan
- ADD rs1=7, imm=-3, alusrc_b=1, regwr=1, rd=5 → next cycle alu_result_out=4, rd_out=5, regwr_out=1.
- SRA rs1=0x80000000, rs2=4 → 0xF8000000; SLTU 1 vs 0xFFFFFFFF → 1; SLT same operands → 0.
- BLT rs1=-1, rs2=1, pc=0x100, imm=0x20 → redirect=1, redirect_pc=0x120; with mem_stall_in=1 → redirect=0. JALR rs1=0x203, imm=0 → redirect_pc=0x202, PC_plus_4_out=pc+4, jump_out=1.
- MUL 0x12345678 × 0x9ABCDEF0 → ex_stall high 33 cycles, 33 bubbles (regwr_out=0), then alu_result_out=0x242D2080.
- mem_stall_in high 3 cycles with a valid bundle → outputs frozen for 3 cycles, then advance; mem_stall_in asserted in DONE → result delivered the cycle after it drops.
- rst_n low during MUL step 10 → all outputs 0, next MUL restarts full 33-cycle sequence.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32 pipeline: ALU/compare, branch and jump resolution,
// a 32-step shift-add multiplier for MUL, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIT_W-1:0] pc_in,
    input  logic [BIT_W-1:0] rs1_in,
    input  logic [BIT_W-1:0] rs2_in,
    input  logic [BIT_W-1:0] imm_in,
    input  logic             alusrc_a_in,
    input  logic             alusrc_b_in,
    input  logic [3:0]       alu_op_in,
    input  logic             branch_in,
    input  logic [2:0]       br_type_in,
    input  logic             jal_in,
    input  logic             jalr_in,
    input  logic             memrd_in,
    input  logic             memwr_in,
    input  logic             mem2reg_in,
    input  logic             regwr_in,
    input  logic [4:0]       rd_in,
    input  logic             mem_stall_in,
    output logic [BIT_W-1:0] alu_result_out,
    output logic [BIT_W-1:0] mem_wdata_out,
    output logic [BIT_W-1:0] PC_plus_4_out,
    output logic [4:0]       rd_out,
    output logic             memrd_out,
    output logic             memwr_out,
    output logic             mem2reg_out,
    output logic             regwr_out,
    output logic             jump_out,
    output logic             redirect,
    output logic [BIT_W-1:0] redirect_pc,
    output logic             ex_stall
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } mul_state_t;

    mul_state_t       state, state_nxt;
    logic [BIT_W-1:0] mcand, mplier, acc;
    logic [4:0]       cnt;

    logic [BIT_W-1:0] op_a, op_b, alu_res, ex_result, jalr_sum;
    logic [4:0]       shamt;
    logic             is_mul, br_taken;

    assign op_a   = alusrc_a_in ? pc_in : rs1_in;
    assign op_b   = alusrc_b_in ? imm_in : rs2_in;
    assign shamt  = op_b[4:0];
    assign is_mul = (alu_op_in == ALU_MUL);

    // NOTE: every variable written in always_comb gets a value before any
    // branch; a path that leaves one unassigned infers a latch.
    always_comb begin
        alu_res = op_a + op_b;
        case (alu_op_in)
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {{(BIT_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(BIT_W-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (br_type_in)
            3'b000:  br_taken = (rs1_in == rs2_in);
            3'b001:  br_taken = (rs1_in != rs2_in);
            3'b100:  br_taken = ($signed(rs1_in) <  $signed(rs2_in));
            3'b101:  br_taken = ($signed(rs1_in) >= $signed(rs2_in));
            3'b110:  br_taken = (rs1_in <  rs2_in);
            3'b111:  br_taken = (rs1_in >= rs2_in);
            default: br_taken = 1'b0;
        endcase
    end

    assign jalr_sum    = rs1_in + imm_in;
    assign redirect_pc = jalr_in ? {jalr_sum[BIT_W-1:1], 1'b0} : pc_in + imm_in;
    assign redirect    = (jal_in | jalr_in | (branch_in & br_taken)) & ~mem_stall_in;

    // A pending MUL holds decode until its product is sitting in DONE.
    assign ex_stall  = mem_stall_in | (is_mul & (state != ST_DONE));
    assign ex_result = is_mul ? acc : alu_res;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (is_mul && !mem_stall_in) state_nxt = ST_MUL;
            ST_MUL:  if (cnt == 5'd31)            state_nxt = ST_DONE;
            ST_DONE: if (!mem_stall_in)           state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mul && !mem_stall_in) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_result_out <= '0;
            mem_wdata_out  <= '0;
            PC_plus_4_out  <= '0;
            rd_out         <= '0;
            memrd_out      <= 1'b0;
            memwr_out      <= 1'b0;
            mem2reg_out    <= 1'b0;
            regwr_out      <= 1'b0;
            jump_out       <= 1'b0;
        end else if (!mem_stall_in) begin
            if (ex_stall) begin
                alu_result_out <= '0;
                mem_wdata_out  <= '0;
                PC_plus_4_out  <= '0;
                rd_out         <= '0;
                memrd_out      <= 1'b0;
                memwr_out      <= 1'b0;
                mem2reg_out    <= 1'b0;
                regwr_out      <= 1'b0;
                jump_out       <= 1'b0;
            end else begin
                alu_result_out <= ex_result;
                mem_wdata_out  <= rs2_in;
                PC_plus_4_out  <= pc_in + BIT_W'(4);
                rd_out         <= rd_in;
                memrd_out      <= memrd_in;
                memwr_out      <= memwr_in;
                mem2reg_out    <= mem2reg_in;
                regwr_out      <= regwr_in;
                jump_out       <= jal_in | jalr_in;
            end
        end
    end

endmodule
